// File: rtl/panel_pkg.sv
// Shared types and defaults for the front-panel input conditioner.
package panel_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } btn_state_e;

    // Debounce counter width; only needs to reach DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/panel_input_stable_filter.sv
// Two-flop synchroniser followed by a whole-word stability filter; a new word
// is accepted only after it has been seen unchanged for DEBOUNCE_CYCLES cycles.
module stable_filter
    import panel_pkg::*;
#(
    parameter int W               = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] value,
    output logic         changed
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  sync1_reg;
    logic [W-1:0]  sync2_reg;
    logic [W-1:0]  cand_reg,  cand_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic [W-1:0]  value_reg, value_next;
    logic          changed_reg, changed_next;

    always_comb begin
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        value_next   = value_reg;
        changed_next = 1'b0;
        if (sync2_reg != cand_reg) begin
            cand_next = sync2_reg;
            cnt_next  = '0;
        end else if (cnt_reg == CNT_MAX) begin
            // Counter parks here, so the accepted word is rewritten every
            // cycle; only a real difference raises changed.
            value_next   = cand_reg;
            changed_next = (cand_reg != value_reg);
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            cand_reg    <= '0;
            cnt_reg     <= '0;
            value_reg   <= '0;
            changed_reg <= 1'b0;
        end else begin
            sync1_reg   <= raw;
            sync2_reg   <= sync1_reg;
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            value_reg   <= value_next;
            changed_reg <= changed_next;
        end
    end

    assign value   = value_reg;
    assign changed = changed_reg;

endmodule

// File: rtl/panel_input.sv
// Front-panel input conditioner: debounced switch banks plus a one-shot
// EXEC strobe generated by a press/release debounce FSM.
module panel_input
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SW1_W           = 16,
    parameter int SW2_W           = 8
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [SW1_W-1:0] sw1_raw,
    input  logic [SW2_W-1:0] sw2_raw,
    input  logic             btn_exec_n,
    output logic [15:0]      inpval1,
    output logic [15:0]      inpval2,
    output logic             exec,
    output logic             changed
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW1_W-1:0] bank1_value;
    logic [SW2_W-1:0] bank2_value;
    logic             bank1_changed;
    logic             bank2_changed;

    stable_filter #(
        .W               (SW1_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bank1 (
        .clock   (clock),
        .n_reset (n_reset),
        .raw     (sw1_raw),
        .value   (bank1_value),
        .changed (bank1_changed)
    );

    stable_filter #(
        .W               (SW2_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bank2 (
        .clock   (clock),
        .n_reset (n_reset),
        .raw     (sw2_raw),
        .value   (bank2_value),
        .changed (bank2_changed)
    );

    assign inpval1 = 16'(bank1_value);
    assign inpval2 = 16'(bank2_value);
    assign changed = bank1_changed | bank2_changed;

    logic          btn_sync1_reg;
    logic          btn_sync2_reg;
    logic          btn_down;
    btn_state_e    state_reg, state_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic          exec_reg,  exec_next;

    assign btn_down = ~btn_sync2_reg;

    always_comb begin
        state_next = state_reg;
        exec_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_down) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_down) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = HELD;
                    exec_next  = 1'b1;
                end
            end
            HELD: begin
                if (!btn_down) state_next = REL_WAIT;
            end
            REL_WAIT: begin
                if (btn_down) begin
                    state_next = HELD;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                end
            end
            default: state_next = REL_WAIT;
        endcase

        // One counter shared by all states: restarts on every transition.
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    // Starting in REL_WAIT means a button held through reset must be
    // released and pressed again before it can fire.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            btn_sync1_reg <= 1'b1;
            btn_sync2_reg <= 1'b1;
            state_reg     <= REL_WAIT;
            cnt_reg       <= '0;
            exec_reg      <= 1'b0;
        end else begin
            btn_sync1_reg <= btn_exec_n;
            btn_sync2_reg <= btn_sync1_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            exec_reg      <= exec_next;
        end
    end

    assign exec = exec_reg;

endmodule

// File: tb/tb_panel_input.sv
// Self-checking bench for panel_input: directed panel scenarios followed by
// randomized switch/button activity, all compared against a run-length model.
module tb_panel_input;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        n_reset;
    logic [15:0] sw1_raw;
    logic [7:0]  sw2_raw;
    logic        btn_exec_n;
    logic [15:0] inpval1;
    logic [15:0] inpval2;
    logic        exec;
    logic        changed;

    panel_input #(
        .DEBOUNCE_CYCLES (DC),
        .SW1_W           (16),
        .SW2_W           (8)
    ) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .sw1_raw    (sw1_raw),
        .sw2_raw    (sw2_raw),
        .btn_exec_n (btn_exec_n),
        .inpval1    (inpval1),
        .inpval2    (inpval2),
        .exec       (exec),
        .changed    (changed)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a word is accepted once the synchronised value has been
    // sampled unchanged on DC+1 consecutive edges; the button arms after DC+1
    // released samples and fires once after DC+1 pressed samples while armed.
    logic [15:0] m_d1[2], m_d2[2], m_rv[2], m_out[2];
    int          m_rl[2];
    logic        m_bd1, m_bd2, m_armed, m_exec, m_chg;
    int          m_hi, m_lo;

    int edge_n    = 0;
    int exec_cnt  = 0;
    int chg_cnt   = 0;
    bit seen_5a   = 0;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b]  = '0;
            m_d2[b]  = '0;
            m_rv[b]  = '0;
            m_out[b] = '0;
            m_rl[b]  = 1;
        end
        m_bd1   = 1'b1;
        m_bd2   = 1'b1;
        m_hi    = 1;
        m_lo    = 0;
        m_armed = 1'b0;
        m_exec  = 1'b0;
        m_chg   = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] raw[2];
        logic [15:0] s;
        logic        bs;
        raw[0] = sw1_raw;
        raw[1] = {8'h00, sw2_raw};
        m_chg  = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s       = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            if (s == m_rv[b]) begin
                if (m_rl[b] <= DC) m_rl[b]++;
            end else begin
                m_rv[b] = s;
                m_rl[b] = 1;
            end
            if (m_rl[b] >= DC + 1) begin
                if (m_out[b] != s) m_chg = 1'b1;
                m_out[b] = s;
            end
        end
        bs     = m_bd2;
        m_bd2  = m_bd1;
        m_bd1  = btn_exec_n;
        m_exec = 1'b0;
        if (!bs) begin
            m_lo++;
            m_hi = 0;
        end else begin
            m_hi++;
            m_lo = 0;
        end
        if (m_armed && m_lo >= DC + 1) begin
            m_exec  = 1'b1;
            m_armed = 1'b0;
        end
        if (!m_armed && m_hi >= DC + 1) m_armed = 1'b1;
    endtask

    task automatic compare_all();
        check_val("inpval1", inpval1, m_out[0]);
        check_val("inpval2", inpval2, m_out[1]);
        check_val("exec", exec, m_exec);
        check_val("changed", changed, m_chg);
    endtask

    // One clock: model advances on the edge, outputs checked 1 time unit later,
    // returns on the falling edge ready for the next stimulus.
    task automatic tick();
        @(posedge clock);
        if (!n_reset) model_reset();
        else          model_edge();
        #1;
        compare_all();
        edge_n++;
        if (exec)    exec_cnt++;
        if (changed) chg_cnt++;
        if (inpval2 == 16'h005A) seen_5a = 1;
        @(negedge clock);
    endtask

    task automatic pulse_reset(input int cycles);
        n_reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < cycles; i++) tick();
        n_reset = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [15:0] pool1[4];
    logic [7:0]  pool2[4];

    initial begin
        int base;
        int d1, d2, db;
        pool1 = '{16'h0000, 16'hFFFF, 16'h1234, 16'hBEEF};
        pool2 = '{8'h00, 8'hA5, 8'h5A, 8'hFF};

        // 1: reset with switches up, then acceptance on the 7th edge
        n_reset    = 1'b0;
        sw1_raw    = 16'hFFFF;
        sw2_raw    = 8'h00;
        btn_exec_n = 1'b1;
        model_reset();
        #1;
        check_val("t1_rst_inpval1", inpval1, 16'h0000);
        check_val("t1_rst_exec", exec, 1'b0);
        @(negedge clock);
        ticks(3);
        check_val("t1_in_rst_inpval1", inpval1, 16'h0000);
        n_reset = 1'b1;
        base = chg_cnt;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6) check_val("t1_edge6_inpval1", inpval1, 16'h0000);
            if (k == 7) begin
                check_val("t1_edge7_inpval1", inpval1, 16'hFFFF);
                check_val("t1_edge7_changed", changed, 1'b1);
            end
        end
        check_val("t1_changed_count", chg_cnt - base, 1);

        // 2: sw2 glitch must never reach the output
        sw2_raw = 8'hA5;
        ticks(2);
        sw2_raw = 8'h5A;
        ticks(2);
        sw2_raw = 8'hA5;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) check_val("t2_edge6_inpval2", inpval2, 16'h0000);
            if (k == 7) check_val("t2_edge7_inpval2", inpval2, 16'h00A5);
        end
        check_val("t2_no_glitch", seen_5a, 1'b0);

        // 3: one long press -> one exec, 7 edges in, none on release
        base = exec_cnt;
        btn_exec_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (exec) check_val("t3_exec_edge", k, 7);
        end
        btn_exec_n = 1'b1;
        ticks(20);
        check_val("t3_exec_count", exec_cnt - base, 1);

        // 4: bouncing press, then held low
        base = exec_cnt;
        for (int i = 0; i < 3; i++) begin
            btn_exec_n = 1'b0;
            ticks(2);
            btn_exec_n = 1'b1;
            ticks(2);
        end
        btn_exec_n = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (exec) check_val("t4_exec_edge", k, 7);
        end
        check_val("t4_exec_count", exec_cnt - base, 1);
        btn_exec_n = 1'b1;
        ticks(15);

        // 5: button held across reset -> nothing until re-pressed
        base = exec_cnt;
        btn_exec_n = 1'b0;
        pulse_reset(2);
        ticks(15);
        check_val("t5_held_no_exec", exec_cnt - base, 0);
        btn_exec_n = 1'b1;
        ticks(10);
        btn_exec_n = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (exec) check_val("t5_exec_edge", k, 7);
        end
        check_val("t5_exec_count", exec_cnt - base, 1);
        btn_exec_n = 1'b1;
        ticks(15);

        // 6: switch change and press together; then reset mid-press
        sw1_raw    = 16'h1234;
        btn_exec_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 7) begin
                check_val("t6_same_exec", exec, 1'b1);
                check_val("t6_same_changed", changed, 1'b1);
                check_val("t6_same_inpval1", inpval1, 16'h1234);
            end
        end
        btn_exec_n = 1'b1;
        ticks(10);
        base = exec_cnt;
        btn_exec_n = 1'b0;
        ticks(3);
        pulse_reset(1);
        check_val("t6_rst_inpval1", inpval1, 16'h0000);
        ticks(15);
        check_val("t6_rst_no_exec", exec_cnt - base, 0);
        check_val("t6_refill_inpval1", inpval1, 16'h1234);
        btn_exec_n = 1'b1;
        ticks(10);

        // Randomized activity against the model
        d1 = 0;
        d2 = 0;
        db = 0;
        for (int c = 0; c < 1500; c++) begin
            if (d1 == 0) begin
                sw1_raw = pool1[$urandom_range(0, 3)];
                d1 = $urandom_range(1, 9);
            end
            if (d2 == 0) begin
                sw2_raw = pool2[$urandom_range(0, 3)];
                d2 = $urandom_range(1, 9);
            end
            if (db == 0) begin
                btn_exec_n = 1'($urandom_range(0, 1));
                db = $urandom_range(1, 10);
            end
            d1--;
            d2--;
            db--;
            if ($urandom_range(0, 299) == 0) pulse_reset(1);
            else                             tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
